// File: rtl/itree_config_loader_if.sv
// Byte-serial configuration stream in, committed isolation-tree image out.
// The master drives the stream; the slave is the loader.
interface itree_config_loader_if #(
  parameter int unsigned TREE_BITS = 256
);
  logic [7:0]           cfg_byte;
  logic                 cfg_valid;
  logic                 cfg_abort;
  logic                 cfg_ready;
  logic [TREE_BITS-1:0] itree_input;
  logic                 load_itree;
  logic                 busy;
  logic                 frame_error;
  logic [7:0]           load_count;

  modport master (
    output cfg_byte, cfg_valid, cfg_abort,
    input  cfg_ready, itree_input, load_itree, busy, frame_error, load_count
  );

  modport slave (
    input  cfg_byte, cfg_valid, cfg_abort,
    output cfg_ready, itree_input, load_itree, busy, frame_error, load_count
  );
endinterface

// File: rtl/itree_config_loader.sv
// Assembles a SYNC-framed byte stream into a tree image and commits it with a one-cycle strobe.
// Define ITREE_CHECKSUM_EN to require a trailing mod-256 zero-sum checksum byte per frame.
module itree_config_loader #(
  parameter int unsigned TREE_BITS = 256,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input logic                  clk,
  input logic                  reset,
  itree_config_loader_if.slave bus
);
  localparam int unsigned NUM_BYTES = TREE_BITS / 8;
  localparam int unsigned CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StCommit
`ifdef ITREE_CHECKSUM_EN
    , StCheck
`endif
  } state_e;

  state_e               r_state;
  logic [TREE_BITS-1:0] r_shadow;
  logic [TREE_BITS-1:0] r_itree;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_load;
  logic                 r_busy;
  logic                 r_cfg_ready;
  logic [7:0]           r_load_count;
  logic [TREE_BITS-1:0] w_shadow_next;
  logic                 w_accept;

  assign w_accept = bus.cfg_valid && r_cfg_ready;

  // Shadow image with the current byte merged at its little-endian slot.
  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[{r_cnt, 3'b000} +: 8] = bus.cfg_byte;
  end

`ifdef ITREE_CHECKSUM_EN
  logic [7:0] r_acc;
  logic [7:0] w_sum;
  logic       r_frame_error;
  assign w_sum = r_acc + bus.cfg_byte;
  assign bus.frame_error = r_frame_error;
`else
  assign bus.frame_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_shadow     <= '0;
      r_itree      <= '0;
      r_cnt        <= '0;
      r_load       <= 1'b0;
      r_busy       <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_load_count <= 8'd0;
`ifdef ITREE_CHECKSUM_EN
      r_acc         <= 8'd0;
      r_frame_error <= 1'b0;
`endif
    end else begin
      r_load <= 1'b0;
`ifdef ITREE_CHECKSUM_EN
      r_frame_error <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          if (w_accept && bus.cfg_byte == SYNC_BYTE) begin
            r_state <= StPayload;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
`ifdef ITREE_CHECKSUM_EN
            r_acc   <= 8'd0;
`endif
          end
        end
        StPayload: begin
          if (bus.cfg_abort) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (w_accept) begin
            r_shadow <= w_shadow_next;
            r_cnt    <= r_cnt + 1'b1;
`ifdef ITREE_CHECKSUM_EN
            r_acc    <= w_sum;
            if (r_cnt == LAST_IDX) r_state <= StCheck;
`else
            // Commit side effects land on this edge so they are visible during StCommit.
            if (r_cnt == LAST_IDX) begin
              r_state      <= StCommit;
              r_cfg_ready  <= 1'b0;
              r_itree      <= w_shadow_next;
              r_load       <= 1'b1;
              r_load_count <= (r_load_count == 8'hFF) ? r_load_count : r_load_count + 8'd1;
            end
`endif
          end
        end
`ifdef ITREE_CHECKSUM_EN
        StCheck: begin
          if (bus.cfg_abort) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (w_accept) begin
            if (w_sum == 8'd0) begin
              r_state      <= StCommit;
              r_cfg_ready  <= 1'b0;
              r_itree      <= r_shadow;
              r_load       <= 1'b1;
              r_load_count <= (r_load_count == 8'hFF) ? r_load_count : r_load_count + 8'd1;
            end else begin
              r_state       <= StIdle;
              r_busy        <= 1'b0;
              r_frame_error <= 1'b1;
            end
          end
        end
`endif
        StCommit: begin
          r_state     <= StIdle;
          r_busy      <= 1'b0;
          r_cfg_ready <= 1'b1;
        end
        default: begin
          r_state     <= StIdle;
          r_busy      <= 1'b0;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cfg_ready   = r_cfg_ready;
  assign bus.itree_input = r_itree;
  assign bus.load_itree  = r_load;
  assign bus.busy        = r_busy;
  assign bus.load_count  = r_load_count;
endmodule
